imm_prefix_sequencer: RTL and testbench

- Sits between instruction decode and the ALU/AGU operand mux of the 16-bit RISC core.
- Accepts 16-bit instruction words over a valid/ready handshake and produces one 16-bit immediate operand per non-prefix instruction.
- Chooses sign- or zero-extension of imm8 per opcode.
- Sequences the two-instruction PFX form: PFX supplies the high byte, the next instruction supplies the low byte, giving a full 16-bit constant.

---
 rtl/imm_prefix_sequencer_pkg.sv | 33 +++
 rtl/imm_prefix_sequencer_merge.sv | 29 ++
 rtl/imm_prefix_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_imm_prefix_sequencer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/imm_prefix_sequencer_pkg.sv
// imm_seq_pkg: shared constants for the immediate prefix sequencer.
//   - opcode encodings of the 16-bit RISC core
//   - default sign-extension mask (bit k set = opcode k sign-extends)
//   - sequencer state encoding
//   - instruction field positions: [15:12] opcode, [11:8] rd, [7:0] imm8
package imm_seq_pkg;

  localparam logic [3:0] OP_ADDI = 4'd0;
  localparam logic [3:0] OP_SUBI = 4'd1;
  localparam logic [3:0] OP_ANDI = 4'd2;
  localparam logic [3:0] OP_ORI  = 4'd3;
  localparam logic [3:0] OP_LDI  = 4'd4;
  localparam logic [3:0] OP_LD   = 4'd5;
  localparam logic [3:0] OP_ST   = 4'd6;
  localparam logic [3:0] OP_BEQ  = 4'd7;
  localparam logic [3:0] OP_BNE  = 4'd8;
  localparam logic [3:0] OP_PFX  = 4'd15;

  localparam logic [15:0] SEXT_MASK_DEF = 16'h01F3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HELD = 1'b1
  } seq_state_t;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 8;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

endpackage

// File: rtl/imm_prefix_sequencer_merge.sv
// imm_merge: combinational operand former.
//   imm8    : low immediate byte from the current instruction
//   hi_byte : high byte captured from a preceding prefix
//   merge   : 1 = concatenate {hi_byte, imm8}
//   sext    : 1 = sign-extend imm8, 0 = zero-extend (ignored when merging)
//   imm     : DATA_W-bit operand
module imm_merge #(
  parameter int IMM_W  = 8,
  parameter int DATA_W = 16
) (
  input  logic [IMM_W-1:0]  imm8,
  input  logic [IMM_W-1:0]  hi_byte,
  input  logic              merge,
  input  logic              sext,
  output logic [DATA_W-1:0] imm
);

  always_comb begin
    imm = '0;
    if (merge) begin
      imm = DATA_W'({hi_byte, imm8});
    end else if (sext) begin
      imm = {{(DATA_W-IMM_W){imm8[IMM_W-1]}}, imm8};
    end else begin
      imm = {{(DATA_W-IMM_W){1'b0}}, imm8};
    end
  end

endmodule

// File: rtl/imm_prefix_sequencer.sv
// imm_prefix_sequencer: turns decoded instruction words into one immediate
// operand per non-prefix instruction. A PFX instruction holds its imm8 as the
// high byte of the next instruction's operand; a held prefix that is not
// followed within PFX_TIMEOUT cycles, or is replaced by another PFX, raises a
// one-cycle pfx_err.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   instr_valid/ready     instruction handshake (ready = !imm_valid || imm_ready)
//   instr[15:0]           [15:12] opcode, [11:8] rd, [7:0] imm8
//   imm_valid/ready       operand handshake, single output register
//   imm, imm_op, imm_rd   operand and the instruction fields that produced it
//   imm_sext, imm_merged  extension kind / formed from a prefix high byte
//   pfx_err               one-cycle pulse: prefix overwritten or timed out
//   stat_*                saturating event counters (only with IMM_STATS_EN)
//
// Build option: define IMM_STATS_EN to add the stat_sext/stat_zext/
// stat_merged/stat_err counter outputs.
//
// state   | meaning
// --------+--------------------------------------------
// ST_IDLE | no prefix held
// ST_HELD | hi_byte holds a prefix, timer counting down
module imm_prefix_sequencer
  import imm_seq_pkg::*;
#(
  parameter int                     OPCODE_W    = 4,
  parameter int                     IMM_W       = 8,
  parameter int                     DATA_W      = 16,
  parameter logic [2**OPCODE_W-1:0] SEXT_MASK   = SEXT_MASK_DEF,
  parameter logic [OPCODE_W-1:0]    PFX_OPCODE  = OP_PFX,
  parameter int                     PFX_TIMEOUT = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                instr_valid,
  input  logic [15:0]         instr,
  output logic                instr_ready,
  output logic                imm_valid,
  input  logic                imm_ready,
  output logic [DATA_W-1:0]   imm,
  output logic [OPCODE_W-1:0] imm_op,
  output logic [3:0]          imm_rd,
  output logic                imm_sext,
  output logic                imm_merged,
`ifdef IMM_STATS_EN
  output logic [15:0]         stat_sext,
  output logic [15:0]         stat_zext,
  output logic [15:0]         stat_merged,
  output logic [15:0]         stat_err,
`endif
  output logic                pfx_err
);

  localparam int TMR_W = (PFX_TIMEOUT < 2) ? 1 : $clog2(PFX_TIMEOUT + 1);

  seq_state_t          state, state_nxt;
  logic [IMM_W-1:0]    hi_byte, hi_byte_nxt;
  logic [TMR_W-1:0]    timer, timer_nxt;
  logic                err_nxt;
  logic                load;
  logic                merge;
  logic                sext_sel;
  logic                accept;
  logic                is_pfx;
  logic [OPCODE_W-1:0] op;
  logic [3:0]          rd;
  logic [IMM_W-1:0]    imm8;
  logic [DATA_W-1:0]   imm_new;

  assign op   = instr[OP_MSB:OP_LSB];
  assign rd   = instr[RD_MSB:RD_LSB];
  assign imm8 = instr[IMM_MSB:IMM_LSB];

  assign instr_ready = !imm_valid || imm_ready;
  assign accept      = instr_valid && instr_ready;
  assign is_pfx      = (op == PFX_OPCODE);
  // A merged operand is always reported as not sign-extended.
  assign sext_sel    = SEXT_MASK[op] && !merge;

  always_comb begin
    state_nxt   = state;
    hi_byte_nxt = hi_byte;
    timer_nxt   = timer;
    err_nxt     = 1'b0;
    load        = 1'b0;
    merge       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (is_pfx) begin
            hi_byte_nxt = imm8;
            timer_nxt   = TMR_W'(PFX_TIMEOUT);
            state_nxt   = ST_HELD;
          end else begin
            load = 1'b1;
          end
        end
      end
      ST_HELD: begin
        // An accepted instruction takes priority over an expiring timer.
        if (accept) begin
          if (is_pfx) begin
            hi_byte_nxt = imm8;
            timer_nxt   = TMR_W'(PFX_TIMEOUT);
            err_nxt     = 1'b1;
          end else begin
            load      = 1'b1;
            merge     = 1'b1;
            state_nxt = ST_IDLE;
          end
        end else if (PFX_TIMEOUT != 0) begin
          if (timer == TMR_W'(1)) begin
            timer_nxt = '0;
            err_nxt   = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            timer_nxt = timer - TMR_W'(1);
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  imm_merge #(
    .IMM_W  (IMM_W),
    .DATA_W (DATA_W)
  ) u_merge (
    .imm8    (imm8),
    .hi_byte (hi_byte),
    .merge   (merge),
    .sext    (sext_sel),
    .imm     (imm_new)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      hi_byte    <= '0;
      timer      <= '0;
      pfx_err    <= 1'b0;
      imm_valid  <= 1'b0;
      imm        <= '0;
      imm_op     <= '0;
      imm_rd     <= '0;
      imm_sext   <= 1'b0;
      imm_merged <= 1'b0;
    end else begin
      state   <= state_nxt;
      hi_byte <= hi_byte_nxt;
      timer   <= timer_nxt;
      pfx_err <= err_nxt;
      if (load) begin
        imm_valid  <= 1'b1;
        imm        <= imm_new;
        imm_op     <= op;
        imm_rd     <= rd;
        imm_sext   <= sext_sel;
        imm_merged <= merge;
      end else if (imm_ready) begin
        imm_valid <= 1'b0;
      end
    end
  end

`ifdef IMM_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_sext   <= '0;
      stat_zext   <= '0;
      stat_merged <= '0;
      stat_err    <= '0;
    end else begin
      if (load && sext_sel && stat_sext != 16'hFFFF)
        stat_sext <= stat_sext + 16'd1;
      if (load && !sext_sel && !merge && stat_zext != 16'hFFFF)
        stat_zext <= stat_zext + 16'd1;
      if (load && merge && stat_merged != 16'hFFFF)
        stat_merged <= stat_merged + 16'd1;
      if (err_nxt && stat_err != 16'hFFFF)
        stat_err <= stat_err + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_imm_prefix_sequencer.sv
// Scoreboard bench for imm_prefix_sequencer: expected operands are queued as
// instructions are offered and popped when the output handshake completes.
module tb_imm_prefix_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic [15:0] instr = 16'h0000;
  logic        instr_ready;
  logic        imm_valid;
  logic        imm_ready = 1'b0;
  logic [15:0] imm;
  logic [3:0]  imm_op;
  logic [3:0]  imm_rd;
  logic        imm_sext;
  logic        imm_merged;
  logic        pfx_err;
`ifdef IMM_STATS_EN
  logic [15:0] stat_sext, stat_zext, stat_merged, stat_err;
`endif

  imm_prefix_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .imm_valid   (imm_valid),
    .imm_ready   (imm_ready),
    .imm         (imm),
    .imm_op      (imm_op),
    .imm_rd      (imm_rd),
    .imm_sext    (imm_sext),
    .imm_merged  (imm_merged),
`ifdef IMM_STATS_EN
    .stat_sext   (stat_sext),
    .stat_zext   (stat_zext),
    .stat_merged (stat_merged),
    .stat_err    (stat_err),
`endif
    .pfx_err     (pfx_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] imm;
    logic [3:0]  op;
    logic [3:0]  rd;
    logic        sext;
    logic        merged;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   pop_cyc[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   err_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (pfx_err) err_cnt++;
      if (imm_valid && imm_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_out", sb.size(), 1);
        end else begin
          mon_e = sb.pop_front();
          check("imm",        imm,        mon_e.imm);
          check("imm_op",     imm_op,     mon_e.op);
          check("imm_rd",     imm_rd,     mon_e.rd);
          check("imm_sext",   imm_sext,   mon_e.sext);
          check("imm_merged", imm_merged, mon_e.merged);
          pop_cyc.push_back(cyc);
        end
      end
    end
  end

  task automatic expect_out(input logic [15:0] v, input logic [3:0] op, input logic [3:0] rd,
                            input logic sx, input logic mg);
    exp_t e;
    e.imm = v; e.op = op; e.rd = rd; e.sext = sx; e.merged = mg;
    sb.push_back(e);
  endtask

  // Offers one instruction; returns the cycle count just after its accept edge.
  task automatic send(input logic [3:0] op, input logic [3:0] rd, input logic [7:0] v,
                      output int acc_cyc);
    bit got = 1'b0;
    instr       = {op, rd, v};
    instr_valid = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = instr_ready;
      @(posedge clk);
      #1;
    end
    instr_valid = 1'b0;
    acc_cyc = cyc;
    check("accept", got, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int a, e0, n0, ec, n;
  bit got;
  logic [3:0]  t_op  [5] = '{4'd7,     4'd8,     4'd6,     4'd5,     4'd2};
  logic [7:0]  t_i8  [5] = '{8'h80,    8'h81,    8'h7F,    8'h80,    8'hFF};
  logic [15:0] t_exp [5] = '{16'hFF80, 16'hFF81, 16'h007F, 16'hFF80, 16'h00FF};
  logic        t_sx  [5] = '{1'b1,     1'b1,     1'b1,     1'b1,     1'b0};

  initial begin
    rst_n = 1'b0;
    imm_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outs", {imm_valid, imm, imm_op, imm_rd, imm_sext, imm_merged, pfx_err}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Sign vs zero extension, one-cycle latency.
    expect_out(16'hFFF0, 4'd0, 4'd1, 1'b1, 1'b0);
    send(4'd0, 4'd1, 8'hF0, a);
    @(negedge clk);
    check("latency1", imm_valid, 1'b1);
    @(posedge clk); #1;
    expect_out(16'h00F0, 4'd3, 4'd2, 1'b0, 1'b0);
    send(4'd3, 4'd2, 8'hF0, a);
    idle(2);

    // Per-opcode extension table.
    for (int i = 0; i < 5; i++) begin
      expect_out(t_exp[i], t_op[i], 4'd9, t_sx[i], 1'b0);
      send(t_op[i], 4'd9, t_i8[i], a);
    end
    idle(2);

    // PFX + LDI merge: a single output, no error.
    e0 = err_cnt; n0 = pop_cyc.size();
    expect_out(16'h1234, 4'd4, 4'd3, 1'b0, 1'b1);
    send(4'hF, 4'd0, 8'h12, a);
    send(4'd4, 4'd3, 8'h34, a);
    idle(3);
    check("pfx_one_out", pop_cyc.size() - n0, 1);
    check("pfx_noerr", err_cnt - e0, 0);

    // Prefix timeout: error exactly 8 cycles after accept, then plain operand.
    e0 = err_cnt;
    send(4'hF, 4'd0, 8'hAA, a);
    got = 1'b0; ec = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (pfx_err) begin got = 1'b1; ec = cyc; end
    end
    check("tmo_seen", got, 1'b1);
    check("tmo_delay", ec - a, 8);
    @(posedge clk); #1;
    expect_out(16'h0080, 4'd2, 4'd5, 1'b0, 1'b0);
    send(4'd2, 4'd5, 8'h80, a);
    idle(3);
    check("tmo_one_pulse", err_cnt - e0, 1);

    // Accept on the expiry cycle wins over the timeout.
    e0 = err_cnt;
    send(4'hF, 4'd0, 8'h77, a);
    idle(7);
    expect_out(16'h7705, 4'd0, 4'd4, 1'b0, 1'b1);
    send(4'd0, 4'd4, 8'h05, a);
    idle(12);
    check("edge_noerr", err_cnt - e0, 0);

    // Prefix overwrite.
    e0 = err_cnt;
    send(4'hF, 4'd0, 8'h11, a);
    send(4'hF, 4'd0, 8'h22, a);
    expect_out(16'h2233, 4'd1, 4'd6, 1'b0, 1'b1);
    send(4'd1, 4'd6, 8'h33, a);
    idle(3);
    check("ovr_err", err_cnt - e0, 1);

    // Backpressure: stalled output holds, then drains one per cycle.
    imm_ready = 1'b0;
    expect_out(16'h0001, 4'd0, 4'd1, 1'b1, 1'b0);
    send(4'd0, 4'd1, 8'h01, a);
    instr = {4'd3, 4'd2, 8'h02};
    instr_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("stall_ready", instr_ready, 1'b0);
      check("stall_imm", imm, 16'h0001);
    end
    @(posedge clk); #1;
    imm_ready = 1'b1;
    expect_out(16'h0002, 4'd3, 4'd2, 1'b0, 1'b0);
    send(4'd3, 4'd2, 8'h02, a);
    expect_out(16'h0003, 4'd3, 4'd3, 1'b0, 1'b0);
    send(4'd3, 4'd3, 8'h03, a);
    idle(3);
    n = pop_cyc.size();
    if (n >= 3) check("back_to_back", pop_cyc[n-1] - pop_cyc[n-3], 2);
    else        check("back_to_back_cnt", n, 3);

    // Reset while a prefix is held discards it.
    send(4'hF, 4'd0, 8'h55, a);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_outs", {imm_valid, imm, imm_op, imm_rd, imm_sext, imm_merged, pfx_err}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    expect_out(16'h0001, 4'd0, 4'd1, 1'b1, 1'b0);
    send(4'd0, 4'd1, 8'h01, a);
    idle(3);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    check("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
